// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and helpers for the register file.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int RF_DATA_W    = 32;
   localparam int RF_ADDR_W    = 5;
   localparam int RF_MAX_DEPTH = 1024;

   typedef logic [RF_DATA_W-1:0] rf_data_t;
   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

   function automatic logic [15:0] popcount(
      input logic [RF_MAX_DEPTH-1:0] v
   );
      logic [15:0] n;
      n = '0;
      for (int i = 0; i < RF_MAX_DEPTH; i++) begin
         n = n + 16'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register load-pending bits, issue handshake and
// registered pending count.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ldIssue,
   input  logic [ADDR_W-1:0]    ldIssueAddr,
   input  logic                 ldValid,
   input  logic [ADDR_W-1:0]    ldAddr,
   output logic                 ldIssueReady,
   output logic [2**ADDR_W-1:0] busy,
   output logic [ADDR_W:0]      busyCnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic                    issueAcc;
   logic [DEPTH-1:0]        busyNext;
   logic [RF_MAX_DEPTH-1:0] busyExt;

   assign ldIssueReady = ~busy[ldIssueAddr];
   assign issueAcc     = ldIssue & ldIssueReady;

   // Next busy vector: return clears, a new accepted issue wins.
   always_comb begin
      busyNext = busy;
      if (ldValid) busyNext[ldAddr] = 1'b0;
      if (issueAcc) busyNext[ldIssueAddr] = 1'b1;
      if (ZERO_REG != 0) busyNext[0] = 1'b0;
   end

   assign busyExt = RF_MAX_DEPTH'(busyNext);

   // Busy bits and their count move together on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= '0;
         busyCnt <= '0;
      end else begin
         busy    <= busyNext;
         busyCnt <= (ADDR_W+1)'(popcount(busyExt));
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, ALU + load write ports, load
// scoreboard, debug port. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 3,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     ld_issue,
   input  logic [ADDR_W-1:0]        ld_issue_addr,
   output logic                     ld_issue_ready,
   input  logic                     ld_valid,
   input  logic [ADDR_W-1:0]        ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_data,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wrZero;
   logic              ldZero;
   logic              wrEnEff;
   logic              ldEnEff;

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) uScoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .ldIssue      (ld_issue),
      .ldIssueAddr  (ld_issue_addr),
      .ldValid      (ld_valid),
      .ldAddr       (ld_addr),
      .ldIssueReady (ld_issue_ready),
      .busy         (busy),
      .busyCnt      (busy_cnt)
   );

   assign wrZero = (ZERO_REG != 0) && (wr_addr == '0);
   assign ldZero = (ZERO_REG != 0) && (ld_addr == '0);

   // Load return beats the ALU on an address collision.
   assign ldEnEff = rst_n & ld_valid & ~ldZero;
   assign wrEnEff = rst_n & wr_en & ~wrZero &
                    ~(ld_valid && (ld_addr == wr_addr));

`ifdef REGFILE_BYPASS_EN
   logic issueAcc;
   assign issueAcc = ld_issue & ld_issue_ready;
`endif

   // Storage array, cleared asynchronously, both write ports per edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wrEnEff) regs[wr_addr] <= wr_data;
         if (ldEnEff) regs[ld_addr] <= ld_data;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : gRd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] rdVal;
      logic              rdBsy;

      assign a = rd_addr[p*ADDR_W +: ADDR_W];

      // Read mux with optional write-first forwarding.
      always_comb begin
         rdVal = regs[a];
         rdBsy = busy[a];
`ifdef REGFILE_BYPASS_EN
         if (ldEnEff && (ld_addr == a)) begin
            rdVal = ld_data;
         end else if (wrEnEff && (wr_addr == a)) begin
            rdVal = wr_data;
         end
         if (ld_valid && (ld_addr == a) &&
             !(issueAcc && (ld_issue_addr == a))) begin
            rdBsy = 1'b0;
         end
`endif
         if ((ZERO_REG != 0) && (a == '0)) begin
            rdVal = '0;
            rdBsy = 1'b0;
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = rdVal;
      assign rd_busy[p]                  = rdBsy;
   end

   assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp
// (default parameters, either REGFILE_BYPASS_EN build).
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            ld_issue;
   logic [AW-1:0]   ld_issue_addr;
   logic            ld_issue_ready;
   logic            ld_valid;
   logic [AW-1:0]   ld_addr;
   logic [DW-1:0]   ld_data;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]   rd_busy;
   logic [AW-1:0]   dbg_addr;
   logic [DW-1:0]   dbg_data;
   logic [AW:0]     busy_cnt;

   logic [63:0] expQ [$];
   int nAssert = 0;
   int nErr    = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_mp #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NR),
      .ZERO_REG (1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .ld_issue       (ld_issue),
      .ld_issue_addr  (ld_issue_addr),
      .ld_issue_ready (ld_issue_ready),
      .ld_valid       (ld_valid),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_busy        (rd_busy),
      .dbg_addr       (dbg_addr),
      .dbg_data       (dbg_data),
      .busy_cnt       (busy_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "timeout");
   end

   function automatic logic [DW-1:0] rdp(input int p);
      return rd_data[p*DW +: DW];
   endfunction

   task automatic setRd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic push(input logic [63:0] e);
      expQ.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      nAssert++;
      if (expQ.size() == 0) begin
         nErr++;
         $display("FAIL %s: observed %0h required <queued value>", tag, obs);
      end else begin
         e = expQ.pop_front();
         assert (obs === e) else begin
            nErr++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, e);
         end
      end
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      ld_issue = 1'b0;
      ld_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      wr_addr = '0; wr_data = '0;
      ld_issue_addr = '0; ld_addr = '0; ld_data = '0;
      rd_addr = '0; dbg_addr = '0;
      setRd(0, 5'd3); setRd(1, 5'd9); setRd(2, 5'd6);
      dbg_addr = 5'd3;

      // reset state
      #1;
      push(0); chk("rst_rd0", 64'(rdp(0)));
      push(0); chk("rst_rd1", 64'(rdp(1)));
      push(0); chk("rst_cnt", 64'(busy_cnt));
      push(1); chk("rst_ready", 64'(ld_issue_ready));
      push(0); chk("rst_dbg", 64'(dbg_data));
      @(negedge clk);
      rst_n = 1'b1;

      // 1: ALU write, same-cycle and next-cycle read
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd87;
      #1;
      push(BYP ? 87 : 0); chk("t1_same", 64'(rdp(0)));
      push(0); chk("t1_dbg_nobyp", 64'(dbg_data));
      @(negedge clk);
      idle();
      #1;
      push(87); chk("t1_next", 64'(rdp(0)));
      push(87); chk("t1_dbg", 64'(dbg_data));

      // 2: write collision, load wins; distinct addresses both land
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd23;
      ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'd94;
      @(negedge clk);
      wr_addr = 5'd8; wr_data = 32'h11;
      ld_addr = 5'd9; ld_data = 32'h22;
      @(negedge clk);
      idle();
      setRd(0, 5'd2); setRd(1, 5'd8); dbg_addr = 5'd9;
      #1;
      push(94); chk("t2_prio", 64'(rdp(0)));
      push(32'h11); chk("t2_wr8", 64'(rdp(1)));
      push(32'h22); chk("t2_ld9", 64'(dbg_data));

      // 3: issue, blocked reissue, return
      @(negedge clk);
      ld_issue = 1'b1; ld_issue_addr = 5'd6;
      #1;
      push(1); chk("t3_ready", 64'(ld_issue_ready));
      @(negedge clk);
      idle();
      #1;
      push(1); chk("t3_busy", 64'(rd_busy[2]));
      push(1); chk("t3_cnt", 64'(busy_cnt));
      @(negedge clk);
      ld_issue = 1'b1; ld_issue_addr = 5'd6;
      #1;
      push(0); chk("t3_notready", 64'(ld_issue_ready));
      @(negedge clk);
      idle();
      ld_valid = 1'b1; ld_addr = 5'd6; ld_data = 32'd63;
      #1;
      push(1); chk("t3_cnt_hold", 64'(busy_cnt));
      push(BYP ? 0 : 1); chk("t3_busy_byp", 64'(rd_busy[2]));
      push(BYP ? 63 : 0); chk("t3_data_byp", 64'(rdp(2)));
      @(negedge clk);
      idle();
      #1;
      push(0); chk("t3_busy_clr", 64'(rd_busy[2]));
      push(0); chk("t3_cnt_clr", 64'(busy_cnt));
      push(63); chk("t3_data", 64'(rdp(2)));

      // 4: same-cycle return and issue to register 5
      @(negedge clk);
      setRd(1, 5'd5);
      ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'd11;
      ld_issue = 1'b1; ld_issue_addr = 5'd5;
      #1;
      push(1); chk("t4_ready", 64'(ld_issue_ready));
      push(0); chk("t4_busy_same", 64'(rd_busy[1]));
      @(negedge clk);
      idle();
      #1;
      push(11); chk("t4_data", 64'(rdp(1)));
      push(1); chk("t4_busy", 64'(rd_busy[1]));
      push(1); chk("t4_cnt", 64'(busy_cnt));
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'd11;
      @(negedge clk);
      idle();
      #1;
      push(0); chk("t4_cnt_clr", 64'(busy_cnt));

      // 5: register 0 is hardwired
      @(negedge clk);
      setRd(0, 5'd0); dbg_addr = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd49;
      ld_issue = 1'b1; ld_issue_addr = 5'd0;
      #1;
      push(1); chk("t5_ready", 64'(ld_issue_ready));
      push(0); chk("t5_same", 64'(rdp(0)));
      @(negedge clk);
      idle();
      #1;
      push(0); chk("t5_data", 64'(rdp(0)));
      push(0); chk("t5_busy", 64'(rd_busy[0]));
      push(0); chk("t5_cnt", 64'(busy_cnt));
      push(0); chk("t5_dbg", 64'(dbg_data));

      // 6: mid-cycle asynchronous reset
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hA1;
      ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'hB4;
      ld_issue = 1'b1; ld_issue_addr = 5'd7;
      @(negedge clk);
      idle();
      setRd(0, 5'd1); setRd(1, 5'd4); setRd(2, 5'd7);
      #1;
      push(32'hA1); chk("t6_pre1", 64'(rdp(0)));
      push(32'hB4); chk("t6_pre4", 64'(rdp(1)));
      push(1); chk("t6_pre_busy7", 64'(rd_busy[2]));
      push(1); chk("t6_pre_cnt", 64'(busy_cnt));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      push(0); chk("t6_rd1", 64'(rdp(0)));
      push(0); chk("t6_rd4", 64'(rdp(1)));
      push(0); chk("t6_rd7", 64'(rdp(2)));
      push(0); chk("t6_busy", 64'(rd_busy));
      push(0); chk("t6_cnt", 64'(busy_cnt));
      push(1); chk("t6_ready", 64'(ld_issue_ready));
      @(negedge clk);
      rst_n = 1'b1;
      ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h77;
      @(negedge clk);
      idle();
      #1;
      push(32'h77); chk("t6_late_ld", 64'(rdp(2)));
      push(0); chk("t6_late_busy", 64'(rd_busy[2]));
      push(0); chk("t6_late_cnt", 64'(busy_cnt));
      push(0); chk("t6_reg1_cleared", 64'(rdp(0)));

      if (expQ.size() != 0) begin
         nErr++;
         $display("FAIL leftover: observed %0d required 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               nAssert, nErr);
      $finish;
   end

endmodule
